branch_predict_unit: RTL and testbench

Dynamic branch predictor for the 5-stage pipelined MIPS core; it replaces the fixed predict-not-taken scheme, in which every taken branch resolved in ID costs one IF flush.
- IF stage: a combinational lookup on the current PC returns a taken prediction and a target.
- ID stage: the branch-resolution logic reports each resolved branch back to this block, which updates a direct-mapped table of saturating counters plus a branch target buffer (BTB).
- The block also flags mispredictions and keeps hit/miss statistics for the testbench.

---
 rtl/branch_predict_unit.sv | 142 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor for the 5-stage MIPS core.
//
// A direct-mapped table of saturating counters plus a branch target buffer.
// The IF stage looks up the current PC combinationally. The ID stage reports
// each resolved branch, and that report trains the table on the next rising edge.
// The block also flags mispredictions and keeps resolved/mispredicted counts.
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous reset, active low
//   if_pc_i            PC being fetched
//   pred_taken_o       combinational taken prediction for if_pc_i
//   pred_target_o      combinational predicted target (0 when not taken)
//   upd_valid_i        a resolved branch is reported this cycle
//   upd_pc_i           PC of the resolved branch
//   upd_taken_i        actual outcome
//   upd_target_i       actual target
//   upd_pred_taken_i   prediction that was made for this branch
//   upd_pred_target_i  target that was predicted for this branch
//   mispredict_o       combinational: resolved branch was mispredicted
//   branch_cnt_o       registered count of resolved branches (saturating)
//   miss_cnt_o         registered count of mispredictions (saturating)
module branch_predict_unit #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [31:0]       branch_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam bit DYN   = (MODE == 1);

  // Counter encodings: reset value is weakly not-taken, allocation weakly taken.
  localparam int unsigned       WNT_INT = (1 << (CNT_W - 1)) - 1;
  localparam int unsigned       WT_INT  = (1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0]  CNT_WNT = WNT_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_WT  = WT_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] cnt_sat_up(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_dn(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [31:0] stat_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              tbl_we;
  logic              unused_pc_bits;

  // The two byte-offset bits never select an entry.
  assign unused_pc_bits = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  // Lookup reads the pre-edge table, so a same-index update this cycle is
  // not yet visible (write-after-read).
  assign lk_idx        = if_pc_i[IDX_W+1:2];
  assign lk_tag        = if_pc_i[ADDR_W-1:IDX_W+2];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = DYN && lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;

  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && upd_pred_taken_i &&
                          (upd_target_i != upd_pred_target_i)));

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (upd_tag_match(upd_idx, upd_tag));

  function automatic logic upd_tag_match(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t);
    return tag_q[i] == t;
  endfunction

  // A miss on a not-taken branch leaves the table alone.
  assign tbl_we = DYN && rst_i && upd_valid_i && (upd_hit || upd_taken_i);

  // Control state: valid bits, counters and statistics.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      if (upd_valid_i)  branch_cnt_o <= stat_sat_inc(branch_cnt_o);
      if (mispredict_o) miss_cnt_o   <= stat_sat_inc(miss_cnt_o);
      if (tbl_we) begin
        if (upd_hit) begin
          cnt_q[upd_idx] <= upd_taken_i ? cnt_sat_up(cnt_q[upd_idx])
                                        : cnt_sat_dn(cnt_q[upd_idx]);
        end else begin
          valid_q[upd_idx] <= 1'b1;
          cnt_q[upd_idx]   <= CNT_WT;
        end
      end
    end
  end

  // Data state: tag and target are only meaningful behind a valid bit.
  // Rewriting the tag on a taken hit stores the same value it already holds.
  always_ff @(posedge clk_i) begin
    if (tbl_we && upd_taken_i) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_i;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;

  logic        pred_taken, mispredict;
  logic [31:0] pred_target, branch_cnt, miss_cnt;
  logic        s_pred_taken, s_mispredict;
  logic [31:0] s_pred_target, s_branch_cnt, s_miss_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.ADDR_W(32), .ENTRIES(64), .CNT_W(2), .MODE(1)) dut (
    .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .mispredict_o(mispredict),
    .branch_cnt_o(branch_cnt), .miss_cnt_o(miss_cnt)
  );

  branch_predict_unit #(.ADDR_W(32), .ENTRIES(64), .CNT_W(2), .MODE(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
    .pred_taken_o(s_pred_taken), .pred_target_o(s_pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .mispredict_o(s_mispredict),
    .branch_cnt_o(s_branch_cnt), .miss_cnt_o(s_miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    step(); step();
    rst = 1'b1; if_pc = 32'h40;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken: got %0d want 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL rst_pred_target: got %h want 0", pred_target); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL rst_branch_cnt: got %0d want 0", branch_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_miss_cnt: got %0d want 0", miss_cnt); end
    checks++; if (s_miss_cnt !== 32'd0) begin errors++; $display("FAIL rst_s_miss_cnt: got %0d want 0", s_miss_cnt); end
  endtask

  task automatic test_allocate();
    if_pc = 32'h40;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %0d want 1", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_same_cycle_pred: got %0d want 0", pred_taken); end
    step(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %0d want 1", pred_taken); end
    checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL alloc_pred_target: got %h want 100", pred_target); end
    checks++; if (branch_cnt !== 32'd1) begin errors++; $display("FAIL alloc_branch_cnt: got %0d want 1", branch_cnt); end
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL alloc_miss_cnt: got %0d want 1", miss_cnt); end
    // mispredict is qualified by upd_valid
    upd_taken = 1'b1; upd_pred_taken = 1'b0; #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mispredict_unqualified: got %0d want 0", mispredict); end
  endtask

  task automatic test_saturation();
    if_pc = 32'h40;
    // cnt 2 -> 1
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_nt1_pred: got %0d want 0", pred_taken); end
    checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL sat_nt1_target: got %h want 0", pred_target); end
    // cnt 1 -> 0, then stays at 0
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); step();
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor_pred: got %0d want 0", pred_taken); end
    // cnt 0 -> 1: still not taken
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_up1_pred: got %0d want 0", pred_taken); end
    // cnt 1 -> 2
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_up2_pred: got %0d want 1", pred_taken); end
    // cnt 2 -> 3 -> 3
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step();
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_ceil_pred: got %0d want 1", pred_taken); end
    checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL sat_ceil_target: got %h want 100", pred_target); end
    checks++; if (branch_cnt !== 32'd8) begin errors++; $display("FAIL sat_branch_cnt: got %0d want 8", branch_cnt); end
    checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL sat_miss_cnt: got %0d want 2", miss_cnt); end
    // cnt 3 -> 2: still taken, proves it held at 3
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_back_to_2_pred: got %0d want 1", pred_taken); end
  endtask

  task automatic test_aliasing();
    if_pc = 32'h140; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_before_pred: got %0d want 0", pred_taken); end
    upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h0); step(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_after_pred: got %0d want 1", pred_taken); end
    checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL alias_after_target: got %h want 200", pred_target); end
    if_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted_pred: got %0d want 0", pred_taken); end
    checks++; if (branch_cnt !== 32'd10) begin errors++; $display("FAIL alias_branch_cnt: got %0d want 10", branch_cnt); end
  endtask

  task automatic test_same_cycle();
    if_pc = 32'h40;
    // re-allocate 0x40 at weakly taken
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); step();
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL war_this_cycle_pred: got %0d want 1", pred_taken); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL war_mispredict: got %0d want 1", mispredict); end
    step(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL war_next_cycle_pred: got %0d want 0", pred_taken); end
    // target mismatch with both taken; cnt 1 -> 2, target becomes 0x180
    upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h100); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL target_mismatch: got %0d want 1", mispredict); end
    step(); idle(); #1;
    checks++; if (pred_target !== 32'h180) begin errors++; $display("FAIL target_rewrite: got %h want 180", pred_target); end
    checks++; if (branch_cnt !== 32'd13) begin errors++; $display("FAIL war_branch_cnt: got %0d want 13", branch_cnt); end
    checks++; if (miss_cnt !== 32'd7) begin errors++; $display("FAIL war_miss_cnt: got %0d want 7", miss_cnt); end
  endtask

  task automatic test_reset_with_update();
    rst = 1'b0;
    upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    step(); rst = 1'b1; idle();
    if_pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstupd_discarded: got %0d want 0", pred_taken); end
    if_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstupd_cleared: got %0d want 0", pred_taken); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL rstupd_branch_cnt: got %0d want 0", branch_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL rstupd_miss_cnt: got %0d want 0", miss_cnt); end
  endtask

  task automatic test_static_mode();
    if_pc = 32'h40;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); #1;
    checks++; if (s_mispredict !== 1'b1) begin errors++; $display("FAIL static_mispredict: got %0d want 1", s_mispredict); end
    step(); idle(); #1;
    checks++; if (s_pred_taken !== 1'b0) begin errors++; $display("FAIL static_pred: got %0d want 0", s_pred_taken); end
    checks++; if (s_pred_target !== 32'h0) begin errors++; $display("FAIL static_target: got %h want 0", s_pred_target); end
    checks++; if (s_branch_cnt !== 32'd1) begin errors++; $display("FAIL static_branch_cnt: got %0d want 1", s_branch_cnt); end
    checks++; if (s_miss_cnt !== 32'd1) begin errors++; $display("FAIL static_miss_cnt: got %0d want 1", s_miss_cnt); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL dynamic_replay_pred: got %0d want 1", pred_taken); end
  endtask

  initial begin
    #1;
    test_reset();
    test_allocate();
    test_saturation();
    test_aliasing();
    test_same_cycle();
    test_reset_with_update();
    test_static_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
